// File: rtl/tz_select_fsm_if.sv
// Button-pulse and display-side signal bundle for the timezone select controller.
// master = pulse conditioners / display consumer, slave = tz_select_fsm.
interface tz_select_fsm_if #(
    parameter int unsigned N_TZ   = 4,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned OFFS_W = 8
);
    logic                 tick;
    logic                 mode_toggle_p;
    logic [N_TZ-1:0]      tz_p;
    logic                 next_p;
    logic                 prev_p;
    logic                 confirm_p;
    logic                 cancel_p;
    logic                 dst_toggle_p;
    logic                 mode_12h;
    logic [SEL_W-1:0]     tz_sel;
    logic [SEL_W-1:0]     tz_preview;
    logic                 preview_active;
    logic                 dst_on;
    logic [OFFS_W:0]      utc_offset;
    logic                 tz_changed_p;

    modport master (
        output tick, mode_toggle_p, tz_p, next_p, prev_p, confirm_p, cancel_p, dst_toggle_p,
        input  mode_12h, tz_sel, tz_preview, preview_active, dst_on, utc_offset, tz_changed_p
    );

    modport slave (
        input  tick, mode_toggle_p, tz_p, next_p, prev_p, confirm_p, cancel_p, dst_toggle_p,
        output mode_12h, tz_sel, tz_preview, preview_active, dst_on, utc_offset, tz_changed_p
    );
endinterface

// File: rtl/tz_select_fsm.sv
// Timezone / display-mode controller: direct select, previewed next/prev browsing with
// timeout, per-zone DST flags and signed UTC offset of the committed zone.
module tz_select_fsm #(
    parameter int unsigned             N_TZ       = 4,
    parameter int unsigned             SEL_W      = 2,
    parameter int unsigned             DEFAULT_TZ = 0,
    parameter int unsigned             OFFS_W     = 8,
    parameter logic [N_TZ*OFFS_W-1:0]  TZ_OFFSETS = 32'h00EC0424,
    parameter int unsigned             TIMEOUT    = 10
) (
    input logic            clk,
    input logic            rst_n,
    tz_select_fsm_if.slave bus
);

    localparam int unsigned     TimerW = $clog2(TIMEOUT + 1);
    localparam logic [SEL_W-1:0] LastTz = SEL_W'(N_TZ - 1);
    localparam logic [SEL_W-1:0] DefTz  = SEL_W'(DEFAULT_TZ);
    localparam logic [TimerW-1:0] TimerLimit = TimerW'(TIMEOUT);

    typedef enum logic [0:0] {StIdle, StPreview} state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    preview_q, preview_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [N_TZ-1:0]     dst_q, dst_d;
    logic                mode_q, mode_d;
    logic                changed_q, changed_d;

    logic                tz_hit;
    logic [SEL_W-1:0]    tz_idx;
    logic                step_any;
    logic                step_one;
    logic [TimerW-1:0]   timer_inc;
    logic signed [OFFS_W-1:0] offs_tbl [N_TZ];
    logic signed [OFFS_W-1:0] cur_offs;

    function automatic logic [SEL_W-1:0] step_zone(logic [SEL_W-1:0] z, logic up);
        if (up) begin
            return (z == LastTz) ? '0 : z + 1'b1;
        end
        return (z == '0) ? LastTz : z - 1'b1;
    endfunction

    // Lowest set in-range bit wins.
    always_comb begin
        tz_hit = 1'b0;
        tz_idx = '0;
        for (int i = int'(N_TZ) - 1; i >= 0; i--) begin
            if (bus.tz_p[i]) begin
                tz_hit = 1'b1;
                tz_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N_TZ); i++) begin
            offs_tbl[i] = TZ_OFFSETS[i*OFFS_W +: OFFS_W];
        end
    end

    assign step_any  = bus.next_p | bus.prev_p;
    assign step_one  = bus.next_p ^ bus.prev_p;
    assign timer_inc = timer_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sel_q     <= DefTz;
            preview_q <= DefTz;
            timer_q   <= '0;
            dst_q     <= '0;
            mode_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            preview_q <= preview_d;
            timer_q   <= timer_d;
            dst_q     <= dst_d;
            mode_q    <= mode_d;
            changed_q <= changed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        preview_d = preview_q;
        timer_d   = timer_q;
        dst_d     = dst_q;
        mode_d    = mode_q ^ bus.mode_toggle_p;

        // DST toggle targets the zone committed before this cycle's edge.
        if (bus.dst_toggle_p) begin
            dst_d[sel_q] = ~dst_q[sel_q];
        end

        if (tz_hit) begin
            sel_d     = tz_idx;
            preview_d = tz_idx;
            state_d   = StIdle;
            timer_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (step_one) begin
                        preview_d = step_zone(sel_q, bus.next_p);
                        state_d   = StPreview;
                        timer_d   = '0;
                    end
                end
                StPreview: begin
                    if (bus.confirm_p) begin
                        sel_d   = preview_q;
                        state_d = StIdle;
                    end else if (bus.cancel_p) begin
                        preview_d = sel_q;
                        state_d   = StIdle;
                    end else if (step_any) begin
                        if (step_one) begin
                            preview_d = step_zone(preview_q, bus.next_p);
                        end
                        timer_d = '0;
                    end else if (bus.tick) begin
                        if (timer_inc == TimerLimit) begin
                            preview_d = sel_q;
                            state_d   = StIdle;
                            timer_d   = '0;
                        end else begin
                            timer_d = timer_inc;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        changed_d = (sel_d != sel_q);
    end

    always_comb begin
        cur_offs           = offs_tbl[sel_q];
        bus.mode_12h       = mode_q;
        bus.tz_sel         = sel_q;
        bus.tz_preview     = preview_q;
        bus.preview_active = (state_q == StPreview);
        bus.dst_on         = dst_q[sel_q];
        bus.utc_offset     = {cur_offs[OFFS_W-1], cur_offs}
                             + (dst_q[sel_q] ? (OFFS_W + 1)'(4) : '0);
        bus.tz_changed_p   = changed_q;
    end

endmodule

// File: tb/tb_tz_select_fsm.sv
// Randomised bench for tz_select_fsm against an integer-level behavioural model,
// preceded by the directed scenarios for reset, commit, timeout, priority, DST and mode.
module tb_tz_select_fsm;

    localparam int N       = 4;
    localparam int TIMEOUT = 10;
    localparam int DEF_TZ  = 0;
    localparam int OFFS [N] = '{36, 4, -20, 0};

    logic clk;
    logic rst_n;

    tz_select_fsm_if #(.N_TZ(4), .SEL_W(2), .OFFS_W(8)) ifc ();

    tz_select_fsm #(
        .N_TZ      (4),
        .SEL_W     (2),
        .DEFAULT_TZ(0),
        .OFFS_W    (8),
        .TZ_OFFSETS(32'h00EC0424),
        .TIMEOUT   (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    int m_sel, m_prv, m_timer;
    bit m_active, m_mode, m_changed;
    bit m_dst [N];

    // Stimulus for the next cycle
    bit       in_rst_n, in_tick, in_mode, in_next, in_prev, in_conf, in_canc, in_dst;
    bit [3:0] in_tz;

    int pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_in();
        in_rst_n = 1'b1; in_tick = 1'b0; in_mode = 1'b0; in_next = 1'b0; in_prev = 1'b0;
        in_conf  = 1'b0; in_canc = 1'b0; in_dst  = 1'b0; in_tz = 4'b0;
    endtask

    task automatic model_update();
        int old_sel;
        int low;
        if (!in_rst_n) begin
            m_sel = DEF_TZ; m_prv = DEF_TZ; m_active = 0; m_timer = 0;
            m_mode = 0; m_changed = 0;
            for (int i = 0; i < N; i++) m_dst[i] = 0;
            return;
        end
        old_sel = m_sel;
        if (in_dst) m_dst[old_sel] = !m_dst[old_sel];
        if (in_mode) m_mode = !m_mode;
        low = -1;
        for (int i = 0; i < N; i++) begin
            if (in_tz[i] && low < 0) low = i;
        end
        if (low >= 0) begin
            m_sel = low; m_prv = low; m_active = 0; m_timer = 0;
        end else if (m_active) begin
            if (in_conf) begin
                m_sel = m_prv; m_active = 0;
            end else if (in_canc) begin
                m_prv = m_sel; m_active = 0;
            end else if (in_next || in_prev) begin
                if (in_next && !in_prev) m_prv = (m_prv + 1) % N;
                if (in_prev && !in_next) m_prv = (m_prv + N - 1) % N;
                m_timer = 0;
            end else if (in_tick) begin
                m_timer++;
                if (m_timer == TIMEOUT) begin
                    m_prv = m_sel; m_active = 0; m_timer = 0;
                end
            end
        end else if (in_next != in_prev) begin
            m_prv = in_next ? (m_sel + 1) % N : (m_sel + N - 1) % N;
            m_active = 1; m_timer = 0;
        end
        m_changed = (m_sel != old_sel);
    endtask

    task automatic cycle();
        rst_n             = in_rst_n;
        ifc.tick          = in_tick;
        ifc.mode_toggle_p = in_mode;
        ifc.tz_p          = in_tz;
        ifc.next_p        = in_next;
        ifc.prev_p        = in_prev;
        ifc.confirm_p     = in_conf;
        ifc.cancel_p      = in_canc;
        ifc.dst_toggle_p  = in_dst;
        @(posedge clk);
        model_update();
        #1;
        check("tz_sel", 32'(ifc.tz_sel), 32'(m_sel));
        check("tz_preview", 32'(ifc.tz_preview), 32'(m_prv));
        check("preview_active", 32'(ifc.preview_active), 32'(m_active));
        check("mode_12h", 32'(ifc.mode_12h), 32'(m_mode));
        check("dst_on", 32'(ifc.dst_on), 32'(m_dst[m_sel]));
        check("utc_offset", 32'($signed(ifc.utc_offset)),
              32'(OFFS[m_sel] + (m_dst[m_sel] ? 4 : 0)));
        check("tz_changed_p", 32'(ifc.tz_changed_p), 32'(m_changed));
        if (ifc.tz_changed_p) pulses++;
        clear_in();
    endtask

    task automatic do_reset();
        clear_in(); in_rst_n = 1'b0; cycle();
        clear_in(); in_rst_n = 1'b0; cycle();
    endtask

    initial begin
        clear_in();
        pulses = 0;

        // 1: reset defaults
        do_reset();
        check("t1_sel", 32'(ifc.tz_sel), 32'd0);
        check("t1_active", 32'(ifc.preview_active), 32'd0);
        check("t1_mode", 32'(ifc.mode_12h), 32'd0);
        check("t1_utc", 32'(ifc.utc_offset), 32'd36);

        // 2: next, next, confirm
        pulses = 0;
        in_next = 1; cycle();
        in_next = 1; cycle();
        in_conf = 1; cycle();
        cycle();
        check("t2_sel", 32'(ifc.tz_sel), 32'd2);
        check("t2_pulses", 32'(pulses), 32'd1);
        check("t2_utc", 32'(ifc.utc_offset), 32'h1EC);

        // 3: prev from 0 then timeout
        do_reset();
        pulses = 0;
        in_prev = 1; cycle();
        check("t3_preview", 32'(ifc.tz_preview), 32'd3);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            in_tick = 1; cycle();
        end
        check("t3_still_active", 32'(ifc.preview_active), 32'd1);
        in_tick = 1; cycle();
        check("t3_active", 32'(ifc.preview_active), 32'd0);
        check("t3_preview_back", 32'(ifc.tz_preview), 32'd0);
        check("t3_sel", 32'(ifc.tz_sel), 32'd0);
        check("t3_pulses", 32'(pulses), 32'd0);

        // 4: direct select beats confirm
        in_next = 1; cycle();
        in_next = 1; cycle();
        in_prev = 1; cycle();
        in_tz = 4'b1010; in_conf = 1; cycle();
        check("t4_sel", 32'(ifc.tz_sel), 32'd1);
        check("t4_active", 32'(ifc.preview_active), 32'd0);
        check("t4_changed", 32'(ifc.tz_changed_p), 32'd1);

        // 5: DST per zone
        in_dst = 1; cycle();
        check("t5_dst", 32'(ifc.dst_on), 32'd1);
        check("t5_utc", 32'(ifc.utc_offset), 32'd8);
        in_tz = 4'b1000; cycle();
        check("t5_dst_z3", 32'(ifc.dst_on), 32'd0);
        in_tz = 4'b0010; cycle();
        check("t5_dst_z1", 32'(ifc.dst_on), 32'd1);

        // 6: mode toggle with simultaneous next+prev clears the timer
        in_next = 1; cycle();
        for (int i = 0; i < 5; i++) begin
            in_tick = 1; cycle();
        end
        in_mode = 1; in_next = 1; in_prev = 1; in_tick = 1; cycle();
        check("t6_mode", 32'(ifc.mode_12h), 32'd1);
        check("t6_preview", 32'(ifc.tz_preview), 32'd2);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            in_tick = 1; cycle();
        end
        check("t6_timer_cleared", 32'(ifc.preview_active), 32'd1);
        in_tick = 1; cycle();
        check("t6_timeout", 32'(ifc.preview_active), 32'd0);

        // Random phases of varying pulse density
        for (int ph = 0; ph < 60; ph++) begin
            int dens;
            dens = $urandom_range(3, 40);
            for (int c = 0; c < 50; c++) begin
                in_rst_n = ($urandom_range(0, 299) != 0);
                in_tick  = ($urandom_range(0, 1) == 1);
                in_mode  = ($urandom_range(0, dens) == 0);
                in_next  = ($urandom_range(0, dens) == 0);
                in_prev  = ($urandom_range(0, dens) == 0);
                in_conf  = ($urandom_range(0, dens) == 0);
                in_canc  = ($urandom_range(0, dens) == 0);
                in_dst   = ($urandom_range(0, dens) == 0);
                in_tz    = ($urandom_range(0, 2 * dens) == 0) ? 4'($urandom) : 4'b0;
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
